// File: rtl/register_file_sb.sv
// Register file with two read ports, one write port, write-first bypass,
// immediate select on port B and a per-register pending (busy) scoreboard
// that stalls reads of operands whose producing write has not yet landed.
module register_file_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned ZERO_R0  = 0,
    parameter logic [15:0] IMM_MASK = 16'hFFC4
) (
    input  logic              clk0,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [3:0]        codop,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              out_valid,
    output logic              stall
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    logic              imm;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic [DATA_W-1:0] opnd_b;
    logic              pend_a;
    logic              pend_b;
    logic              wr_hit_a;
    logic              wr_hit_b;
    logic              r0_fixed;

    assign r0_fixed = (ZERO_R0 != 0);
    assign imm      = IMM_MASK[codop];
    assign wr_hit_a = wr_en && (wr_addr == addr_a);
    assign wr_hit_b = wr_en && (wr_addr == addr_b);

    // Port A read value with write-first bypass and hard-wired R0
    always_comb begin
        val_a = regs[addr_a];
        if (wr_hit_a) begin
            val_a = wr_data;
        end
        if (r0_fixed && (addr_a == '0)) begin
            val_a = '0;
        end
    end

    // Port B register value with write-first bypass and hard-wired R0
    always_comb begin
        val_b = regs[addr_b];
        if (wr_hit_b) begin
            val_b = wr_data;
        end
        if (r0_fixed && (addr_b == '0)) begin
            val_b = '0;
        end
    end

    // Operand B: zero-extended address field when the opcode selects immediate
    always_comb begin
        opnd_b = val_b;
        if (imm) begin
            opnd_b = DATA_W'(addr_b);
        end
    end

    // Pending operands: busy and not being resolved by this cycle's write
    always_comb begin
        pend_a = busy[addr_a] && !wr_hit_a;
        pend_b = busy[addr_b] && !wr_hit_b;
        if (r0_fixed && (addr_a == '0)) begin
            pend_a = 1'b0;
        end
        if (r0_fixed && (addr_b == '0)) begin
            pend_b = 1'b0;
        end
    end

    assign stall = rd_en && (pend_a || (!imm && pend_b));

    // Scoreboard next state: write clears, accepted issue sets (set wins)
    always_comb begin
        busy_nxt = busy;
        if (wr_en) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (issue && !stall && !(r0_fixed && (issue_addr == '0))) begin
            busy_nxt[issue_addr] = 1'b1;
        end
    end

    // Register array write port
    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
        end else if (wr_en && !(r0_fixed && (wr_addr == '0))) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Scoreboard and registered read results
    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            busy      <= '0;
            a         <= '0;
            b         <= '0;
            out_valid <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (rd_en && !stall) begin
                a         <= val_a;
                b         <= opnd_b;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: two instances (ZERO_R0=0 and ZERO_R0=1) share
// one stimulus stream; an array/rule-based model predicts every output.
module tb_register_file_sb;

    localparam logic [15:0] MASK = 16'hFFC4;

    logic        clk0 = 1'b0;
    logic        rst  = 1'b1;
    logic        rd_en = 1'b0;
    logic [3:0]  codop = 4'd0;
    logic [3:0]  addr_a = 4'd0;
    logic [3:0]  addr_b = 4'd0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [15:0] wr_data = 16'd0;
    logic        issue = 1'b0;
    logic [3:0]  issue_addr = 4'd0;

    logic [15:0] a0, b0, a1, b1;
    logic        ov0, ov1, st0, st1;

    int n_checks = 0;
    int n_fail   = 0;

    register_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0), .IMM_MASK(MASK)) dut0 (
        .clk0(clk0), .rst(rst), .rd_en(rd_en), .codop(codop),
        .addr_a(addr_a), .addr_b(addr_b), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .issue(issue), .issue_addr(issue_addr),
        .a(a0), .b(b0), .out_valid(ov0), .stall(st0));

    register_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1), .IMM_MASK(MASK)) dut1 (
        .clk0(clk0), .rst(rst), .rd_en(rd_en), .codop(codop),
        .addr_a(addr_a), .addr_b(addr_b), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .issue(issue), .issue_addr(issue_addr),
        .a(a1), .b(b1), .out_valid(ov1), .stall(st1));

    always #5 clk0 = ~clk0;

    // ---------------- model ----------------
    logic [15:0] m_reg  [2][16];
    bit          m_busy [2][16];
    logic [15:0] m_a [2];
    logic [15:0] m_b [2];
    bit          m_ov [2];

    function automatic logic [15:0] mval(int k, logic [3:0] x);
        if (k == 1 && x == 4'd0) return 16'd0;
        if (wr_en && wr_addr == x) return wr_data;
        return m_reg[k][x];
    endfunction

    function automatic bit mpend(int k, logic [3:0] x);
        if (k == 1 && x == 4'd0) return 1'b0;
        return m_busy[k][x] && !(wr_en && wr_addr == x);
    endfunction

    function automatic bit mstall(int k);
        return rd_en && (mpend(k, addr_a) || (!MASK[codop] && mpend(k, addr_b)));
    endfunction

    function automatic logic [15:0] mopb(int k);
        if (MASK[codop]) return {12'd0, addr_b};
        return mval(k, addr_b);
    endfunction

    always @(posedge clk0 or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 16; r++) begin
                    m_reg[k][r]  <= 16'd0;
                    m_busy[k][r] <= 1'b0;
                end
                m_a[k]  <= 16'd0;
                m_b[k]  <= 16'd0;
                m_ov[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (rd_en && !mstall(k)) begin
                    m_a[k]  <= mval(k, addr_a);
                    m_b[k]  <= mopb(k);
                    m_ov[k] <= 1'b1;
                end else begin
                    m_ov[k] <= 1'b0;
                end
                if (wr_en) begin
                    m_busy[k][wr_addr] <= 1'b0;
                    if (!(k == 1 && wr_addr == 4'd0)) m_reg[k][wr_addr] <= wr_data;
                end
                if (issue && !mstall(k) && !(k == 1 && issue_addr == 4'd0))
                    m_busy[k][issue_addr] <= 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk0) begin
        chk("cyc_a0",  a0, m_a[0]);
        chk("cyc_b0",  b0, m_b[0]);
        chk("cyc_ov0", {15'd0, ov0}, {15'd0, m_ov[0]});
        chk("cyc_st0", {15'd0, st0}, {15'd0, mstall(0)});
        chk("cyc_a1",  a1, m_a[1]);
        chk("cyc_b1",  b1, m_b[1]);
        chk("cyc_ov1", {15'd0, ov1}, {15'd0, m_ov[1]});
        chk("cyc_st1", {15'd0, st1}, {15'd0, mstall(1)});
    end

    task automatic tick();
        @(posedge clk0);
        #2;
    endtask

    task automatic idle();
        rd_en = 1'b0; wr_en = 1'b0; issue = 1'b0;
    endtask

    task automatic wr(input logic [3:0] ad, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = ad; wr_data = d;
    endtask

    task automatic rd(input logic [3:0] c, input logic [3:0] aa, input logic [3:0] ab);
        rd_en = 1'b1; codop = c; addr_a = aa; addr_b = ab;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        repeat (2) @(posedge clk0);
        #2 rst = 1'b0;
        chk("rst_a0", a0, 16'h0000);
        chk("rst_ov0", {15'd0, ov0}, 16'd0);
        chk("rst_b1", b1, 16'h0000);

        // write then read
        wr(4'd3, 16'h1234); tick();
        idle(); rd(4'd0, 4'd3, 4'd0); tick();
        chk("rd_a0", a0, 16'h1234);
        chk("rd_ov0", {15'd0, ov0}, 16'd1);
        chk("rd_a1", a1, 16'h1234);

        // same-cycle write/read bypass
        idle(); wr(4'd5, 16'hBEEF); rd(4'd0, 4'd5, 4'd0); #1;
        chk("byp_st0", {15'd0, st0}, 16'd0);
        tick();
        chk("byp_a0", a0, 16'hBEEF);

        // immediate vs register for B
        idle(); wr(4'd9, 16'h0077); tick();
        chk("nord_ov0", {15'd0, ov0}, 16'd0);
        idle(); rd(4'd6, 4'd3, 4'd9); tick();
        chk("imm_b0", b0, 16'h0009);
        rd(4'd1, 4'd3, 4'd9); tick();
        chk("reg_b0", b0, 16'h0077);
        chk("reg_a0", a0, 16'h1234);

        // scoreboard stall and release by write
        idle(); issue = 1'b1; issue_addr = 4'd7; tick();
        idle(); rd(4'd6, 4'd7, 4'd9); #1;
        chk("sb_st0", {15'd0, st0}, 16'd1);
        tick();
        chk("sb_ov0", {15'd0, ov0}, 16'd0);
        chk("sb_hold_a0", a0, 16'h1234);
        wr(4'd7, 16'h0042); #1;
        chk("sb_rel_st0", {15'd0, st0}, 16'd0);
        tick();
        chk("sb_rel_a0", a0, 16'h0042);
        chk("sb_rel_ov0", {15'd0, ov0}, 16'd1);

        // hard-wired R0
        idle(); wr(4'd0, 16'hFFFF); tick();
        idle(); rd(4'd6, 4'd0, 4'd2); tick();
        chk("r0_a1", a1, 16'h0000);
        chk("r0_a0", a0, 16'hFFFF);
        idle(); issue = 1'b1; issue_addr = 4'd0; tick();
        idle(); rd(4'd6, 4'd0, 4'd2); #1;
        chk("r0_st1", {15'd0, st1}, 16'd0);
        chk("r0_st0", {15'd0, st0}, 16'd1);
        tick();
        wr(4'd0, 16'h0000); tick();

        // same-edge issue and write: set wins
        idle(); wr(4'd6, 16'h0005); issue = 1'b1; issue_addr = 4'd6; tick();
        idle(); rd(4'd6, 4'd6, 4'd0); #1;
        chk("setwin_st0", {15'd0, st0}, 16'd1);
        // issue under stall is dropped
        issue = 1'b1; issue_addr = 4'd8; tick();
        idle(); wr(4'd6, 16'h0006); tick();
        idle(); rd(4'd6, 4'd8, 4'd0); #1;
        chk("drop_st0", {15'd0, st0}, 16'd0);
        tick();

        // B-operand stall only when not immediate
        idle(); issue = 1'b1; issue_addr = 4'd10; tick();
        idle(); rd(4'd1, 4'd3, 4'd10); #1;
        chk("bst_st1", {15'd0, st1}, 16'd1);
        codop = 4'd6; #1;
        chk("bimm_st1", {15'd0, st1}, 16'd0);
        tick();
        chk("bimm_b1", b1, 16'h000A);
        idle(); wr(4'd10, 16'h0000); tick();

        // asynchronous reset between edges
        idle(); wr(4'd2, 16'h1111); tick();
        idle(); rd(4'd6, 4'd2, 4'd9); issue = 1'b1; issue_addr = 4'd4; tick();
        chk("pre_rst_a0", a0, 16'h1111);
        idle(); rd(4'd6, 4'd4, 4'd9); #1;
        chk("pre_rst_st0", {15'd0, st0}, 16'd1);
        rst = 1'b1; #1;
        chk("arst_a0", a0, 16'h0000);
        chk("arst_ov0", {15'd0, ov0}, 16'd0);
        chk("arst_st0", {15'd0, st0}, 16'd0);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_ov0", {15'd0, ov0}, 16'd1);
        chk("post_rst_a0", a0, 16'h0000);

        // mixed traffic checked by the model each cycle
        for (int i = 0; i < 200; i++) begin
            rd_en      = ($urandom_range(0, 3) != 0);
            codop      = 4'($urandom_range(0, 15));
            addr_a     = 4'($urandom_range(0, 15));
            addr_b     = 4'($urandom_range(0, 15));
            wr_en      = ($urandom_range(0, 1) != 0);
            wr_addr    = 4'($urandom_range(0, 15));
            wr_data    = 16'($urandom);
            issue      = ($urandom_range(0, 3) == 0);
            issue_addr = 4'($urandom_range(0, 15));
            tick();
        end

        idle(); tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
